// File: rtl/dec_scan_pkg.sv
// Shared types and constants for the decoder scan driver.
// Pure declarations: no logic, no latency, no backpressure.
package dec_scan_pkg;
   localparam int SEL_W  = 4;
   localparam int MAX_CH = 16;

   typedef enum logic [1:0] {
      IDLE,
      BLANK,
      DWELL
   } scan_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction
endpackage

// File: rtl/dec_scan_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
// Load takes effect on the next edge; no backpressure.
module dec_scan_timer
   import dec_scan_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] value,
   output logic         done
);
   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= value;
      end else if (cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign done = (cnt == '0);
endmodule

// File: rtl/dec_scan_seq.sv
// Scan driver for the 4-to-16 decoder: sel/en_n registered, first en_n low BLANK_CYC+1 cycles after start,
// no backpressure (start ignored while busy). Define DEC_SCAN_SKIP_EN to add the ch_mask channel-skip input.
module dec_scan_seq
   import dec_scan_pkg::*;
#(
   parameter int NUM_CH    = 16,
   parameter int DWELL_W   = 8,
   parameter int BLANK_CYC = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic               single,
   input  logic [DWELL_W-1:0] dwell,
`ifdef DEC_SCAN_SKIP_EN
   input  logic [NUM_CH-1:0]  ch_mask,
`endif
   output logic [SEL_W-1:0]   sel,
   output logic               en_n,
   output logic               busy,
   output logic               frame_done
);
   localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
   localparam int TW = max_int(DWELL_W, BW);
   localparam logic [TW-1:0] ONE      = TW'(1);
   localparam logic [TW-1:0] BLANK_LD = TW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

   scan_state_t        state;
   logic [SEL_W-1:0]   ch;
   logic [DWELL_W-1:0] dwell_lat;
   logic [DWELL_W-1:0] dwell_eff;
   logic               single_lat;
   logic               stop_req;
   logic               fd_int;
   logic               t_load;
   logic [TW-1:0]      t_value;
   logic               t_done;
   logic [SEL_W-1:0]   first_ch;
   logic [SEL_W-1:0]   next_ch;
   logic [SEL_W-1:0]   wrap_ch;
   logic               none_first;
   logic               is_last;

   assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

`ifdef DEC_SCAN_SKIP_EN
   logic [NUM_CH-1:0] mask_lat;

   // Descending scan leaves the lowest qualifying index in each result.
   always_comb begin
      first_ch   = '0;
      none_first = 1'b1;
      wrap_ch    = '0;
      next_ch    = '0;
      is_last    = 1'b1;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (ch_mask[i]) begin
            first_ch   = SEL_W'(i);
            none_first = 1'b0;
         end
         if (mask_lat[i]) begin
            wrap_ch = SEL_W'(i);
         end
         if (mask_lat[i] && (SEL_W'(i) > ch)) begin
            next_ch = SEL_W'(i);
            is_last = 1'b0;
         end
      end
   end
`else
   assign first_ch   = '0;
   assign none_first = 1'b0;
   assign wrap_ch    = '0;
   assign is_last    = (ch == SEL_W'(NUM_CH - 1));
   assign next_ch    = ch + SEL_W'(1);
`endif

   always_comb begin
      t_load  = 1'b0;
      t_value = '0;
      case (state)
         IDLE: begin
            if (start && !stop && !none_first) begin
               t_load  = 1'b1;
               t_value = (BLANK_CYC > 0) ? BLANK_LD : TW'(dwell_eff) - ONE;
            end
         end
         BLANK: begin
            if (t_done) begin
               t_load  = 1'b1;
               t_value = TW'(dwell_lat) - ONE;
            end
         end
         DWELL: begin
            if (t_done) begin
               t_load  = 1'b1;
               t_value = (BLANK_CYC > 0) ? BLANK_LD : TW'(dwell_lat) - ONE;
            end
         end
         default: ;
      endcase
   end

   dec_scan_timer #(.W(TW)) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (t_load),
      .value (t_value),
      .done  (t_done)
   );

   // Outputs are a registered image of the previous cycle's state and channel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         ch         <= '0;
         dwell_lat  <= '0;
         single_lat <= 1'b0;
         stop_req   <= 1'b0;
         fd_int     <= 1'b0;
         sel        <= '0;
         en_n       <= 1'b1;
         busy       <= 1'b0;
         frame_done <= 1'b0;
`ifdef DEC_SCAN_SKIP_EN
         mask_lat   <= '0;
`endif
      end else begin
         sel        <= ch;
         en_n       <= (state != DWELL);
         busy       <= (state != IDLE);
         frame_done <= fd_int;
         fd_int     <= 1'b0;
         case (state)
            IDLE: begin
               stop_req <= 1'b0;
               ch       <= '0;
               if (start && !stop) begin
                  dwell_lat  <= dwell_eff;
                  single_lat <= single;
`ifdef DEC_SCAN_SKIP_EN
                  mask_lat   <= ch_mask;
`endif
                  if (none_first) begin
                     fd_int <= 1'b1;
                  end else begin
                     ch    <= first_ch;
                     state <= (BLANK_CYC > 0) ? BLANK : DWELL;
                  end
               end
            end
            BLANK: begin
               if (stop) stop_req <= 1'b1;
               if (t_done) state <= DWELL;
            end
            DWELL: begin
               if (stop) stop_req <= 1'b1;
               if (t_done) begin
                  if (is_last) fd_int <= 1'b1;
                  if (stop || stop_req || (is_last && single_lat)) begin
                     state    <= IDLE;
                     ch       <= '0;
                     stop_req <= 1'b0;
                  end else begin
                     ch    <= is_last ? wrap_ch : next_ch;
                     state <= (BLANK_CYC > 0) ? BLANK : DWELL;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dec_scan_seq.sv
// Scoreboard bench for dec_scan_seq: a trace model predicts every output cycle of each scan.
module tb_dec_scan_seq;
   localparam int NUM_CH    = 4;
   localparam int DWELL_W   = 8;
   localparam int BLANK_CYC = 2;

   typedef struct packed {
      logic [3:0] sel;
      logic       en_n;
      logic       busy;
      logic       fd;
   } obs_t;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic               stop = 1'b0;
   logic               single = 1'b0;
   logic [DWELL_W-1:0] dwell = '0;
`ifdef DEC_SCAN_SKIP_EN
   logic [NUM_CH-1:0]  ch_mask = '1;
`endif
   logic [3:0]         sel;
   logic               en_n;
   logic               busy;
   logic               frame_done;

   obs_t exp_q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   n_pop = 0;

   always #5 clk = ~clk;

   dec_scan_seq #(.NUM_CH(NUM_CH), .DWELL_W(DWELL_W), .BLANK_CYC(BLANK_CYC)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .stop       (stop),
      .single     (single),
      .dwell      (dwell),
`ifdef DEC_SCAN_SKIP_EN
      .ch_mask    (ch_mask),
`endif
      .sel        (sel),
      .en_n       (en_n),
      .busy       (busy),
      .frame_done (frame_done)
   );

   function automatic obs_t mk(input int s, input bit e, input bit b, input bit f);
      obs_t o;
      o.sel  = 4'(s);
      o.en_n = e;
      o.busy = b;
      o.fd   = f;
      return o;
   endfunction

   task automatic check(input string name, input obs_t act, input obs_t exp_v);
      n_chk++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s @%0t: got sel=%0d en_n=%0b busy=%0b fd=%0b, expected sel=%0d en_n=%0b busy=%0b fd=%0b",
                  name, $time, act.sel, act.en_n, act.busy, act.fd,
                  exp_v.sel, exp_v.en_n, exp_v.busy, exp_v.fd);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp_v);
      n_chk++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp_v);
      end
   endtask

   // Monitor: every cycle with a pending expectation is compared on the falling edge.
   always @(negedge clk) begin
      obs_t e, a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {sel, en_n, busy, frame_done};
         n_pop++;
         check($sformatf("trace[%0d]", n_pop), a, e);
      end
   end

   task automatic drain(input int stop_at, input bit poke);
      for (int i = 1; exp_q.size() > 0; i++) begin
         if (i > 3000) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout @%0t: %0d expectations left, expected 0", $time, exp_q.size());
            exp_q.delete();
            break;
         end
         stop  = (i == stop_at);
         start = poke && (i == 5);
         @(posedge clk); #1;
      end
      stop  = 1'b0;
      start = 1'b0;
   endtask

   // Model: a frame is, per enabled channel, BLANK_CYC off cycles then max(dwell,1) on cycles.
   task automatic do_scan(input int dw, input bit sg, input int stop_at, input bit poke,
                          input logic [NUM_CH-1:0] mask);
      obs_t t[$];
      obs_t idle;
      int   d, nfr, first, last, e;
      bit   fdnext;
      idle   = mk(0, 1, 0, 0);
      d      = (dw == 0) ? 1 : dw;
      nfr    = sg ? 1 : 3;
      first  = -1;
      last   = -1;
      fdnext = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (mask[c]) begin
            if (first < 0) first = c;
            last = c;
         end
      end
      t.push_back(idle);
      t.push_back(idle);
      if (last < 0) begin
         t.push_back(mk(0, 1, 0, 1));
      end else begin
         for (int f = 0; f < nfr; f++) begin
            for (int c = 0; c < NUM_CH; c++) begin
               if (mask[c]) begin
                  for (int b = 0; b < BLANK_CYC; b++) begin
                     t.push_back(mk(c, 1, 1, fdnext));
                     fdnext = 1'b0;
                  end
                  for (int j = 0; j < d; j++) begin
                     t.push_back(mk(c, 0, 1, fdnext));
                     fdnext = 1'b0;
                  end
                  if (c == last) fdnext = 1'b1;
               end
            end
         end
         if (stop_at > 0) begin
            // Channel in progress at the stop finishes its on-time, then the scan ends.
            e = stop_at + 1;
            while (e < t.size() - 1 &&
                   !(t[e].en_n == 1'b0 && !(t[e+1].en_n == 1'b0 && t[e+1].sel == t[e].sel)))
               e++;
            while (t.size() > e + 1) t.delete(t.size() - 1);
            t.push_back(mk(0, 1, 0, int'(t[e].sel) == last));
         end else begin
            t.push_back(mk(0, 1, 0, 1));
         end
      end
      repeat (3) t.push_back(idle);
      foreach (t[i]) exp_q.push_back(t[i]);

      dwell  = DWELL_W'(dw);
      single = sg;
`ifdef DEC_SCAN_SKIP_EN
      ch_mask = mask;
`endif
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      dwell = DWELL_W'($urandom);
      single = ~sg;
`ifdef DEC_SCAN_SKIP_EN
      ch_mask = NUM_CH'($urandom);
`endif
      drain(stop_at, poke);
   endtask

   initial begin
      int   dw, flen, sa;
      bit   sg, seen;
      obs_t idle_o;
      idle_o = mk(0, 1, 0, 0);

      repeat (3) @(posedge clk);
      #1;
      check("reset_state", {sel, en_n, busy, frame_done}, idle_o);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Single frame, dwell 3: frame_done 21 cycles after start.
      do_scan(3, 1'b1, 0, 1'b0, '1);
      // Continuous, dwell 0, stop during channel 1 of the third frame.
      do_scan(0, 1'b0, 29, 1'b0, '1);
      // start and stop together in IDLE: nothing happens.
      repeat (6) exp_q.push_back(idle_o);
      start = 1'b1;
      stop  = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      stop  = 1'b0;
      drain(0, 1'b0);
      // start while busy is ignored.
      do_scan(3, 1'b1, 0, 1'b1, '1);
      // Stop landing on the last on-cycle of the last channel.
      do_scan(2, 1'b0, 4 * (BLANK_CYC + 2), 1'b0, '1);

`ifdef DEC_SCAN_SKIP_EN
      do_scan(2, 1'b1, 0, 1'b0, 4'b1010);
      do_scan(2, 1'b1, 0, 1'b0, 4'b0000);
      do_scan(1, 1'b0, 20, 1'b0, 4'b0110);
`endif

      for (int r = 0; r < 10; r++) begin
         dw   = $urandom_range(0, 5);
         sg   = 1'($urandom_range(0, 1));
         flen = NUM_CH * (BLANK_CYC + ((dw == 0) ? 1 : dw));
         if (sg) sa = ($urandom_range(0, 1) == 1) ? $urandom_range(1, flen) : 0;
         else    sa = $urandom_range(1, 2 * flen);
         do_scan(dw, sg, sa, 1'b0, '1);
      end

      // Reset asserted during channel 2's on-time clears outputs without a clock edge.
      dwell  = 8'd3;
      single = 1'b1;
`ifdef DEC_SCAN_SKIP_EN
      ch_mask = '1;
`endif
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      seen  = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (sel == 4'd2 && en_n == 1'b0) seen = 1'b1;
      end
      check_int("reach_ch2_dwell", int'(seen), 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset", {sel, en_n, busy, frame_done}, idle_o);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("after_release", {sel, en_n, busy, frame_done}, idle_o);
      do_scan(1, 1'b1, 0, 1'b0, '1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog @%0t: simulation did not finish, %0d failures so far", $time, n_fail);
      $fatal(1, "watchdog");
   end
endmodule
